// File: rtl/adder_switch_cfg_sequencer.sv
`default_nettype none
// ==========================================================================
// adder_switch_cfg_sequencer : steps an edge adder switch through a config table
// Rev 1.0
// ==========================================================================
module adder_switch_cfg_sequencer #(
  parameter int SEL_IN    = 2,
  parameter int NUM_CFG   = 8,
  parameter int CFG_AW    = 3,
  parameter int CNT_W     = 8,
  parameter int DRAIN_CYC = 2
) (
  input  logic                      CLK,
  input  logic                      rst_n,
  input  logic                      i_cfg_wr_en,
  input  logic [CFG_AW-1:0]         i_cfg_wr_addr,
  input  logic [CNT_W+4+SEL_IN-1:0] i_cfg_wr_data,
  input  logic [CFG_AW:0]           i_num_cfg,
  input  logic                      i_start,
  input  logic                      i_data_valid,
  output logic                      o_data_ready,
  output logic                      o_sw_valid,
  output logic                      o_sw_add_en,
  output logic [2:0]                o_sw_cmd,
  output logic [SEL_IN-1:0]         o_sw_sel,
  output logic [CFG_AW-1:0]         o_cfg_idx,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err
);

  localparam int EW = CNT_W + 4 + SEL_IN;
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t             state;
  logic [EW-1:0]      cfg_tbl [NUM_CFG];
  logic [CFG_AW-1:0]  idx;
  logic [CFG_AW:0]    num_q;
  logic [CNT_W-1:0]   beat_cnt;
  logic [DW-1:0]      drain_cnt;

  logic [EW-1:0]      entry;
  logic [CNT_W-1:0]   entry_beats;
  logic               entry_add_en;
  logic [2:0]         entry_cmd;
  logic [SEL_IN-1:0]  entry_sel;
  logic               cmd_legal;
  logic               last_entry;
  logic [CFG_AW:0]    num_eff;

  assign entry        = cfg_tbl[idx];
  assign entry_sel    = entry[SEL_IN-1:0];
  assign entry_cmd    = entry[SEL_IN+2:SEL_IN];
  assign entry_add_en = entry[SEL_IN+3];
  assign entry_beats  = entry[EW-1:SEL_IN+4];
  assign cmd_legal    = (entry_cmd == 3'b010) || (entry_cmd == 3'b011) ||
                        (entry_cmd == 3'b100) || (entry_cmd == 3'b101);
  assign last_entry   = (({1'b0, idx} + {{CFG_AW{1'b0}}, 1'b1}) == num_q);
  // Oversized counts are clamped so idx can never wrap past the table.
  assign num_eff      = (i_num_cfg > (CFG_AW+1)'(NUM_CFG)) ? (CFG_AW+1)'(NUM_CFG) : i_num_cfg;

  assign o_data_ready = (state == RUN);
  assign o_sw_valid   = i_data_valid & o_data_ready;
  assign o_busy       = (state != IDLE);
  assign o_done       = (state == DONE);
  assign o_cfg_idx    = idx;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CFG; i++) cfg_tbl[i] <= '0;
    end else if (i_cfg_wr_en && (state == IDLE)) begin
      cfg_tbl[i_cfg_wr_addr] <= i_cfg_wr_data;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      num_q       <= '0;
      beat_cnt    <= '0;
      drain_cnt   <= '0;
      o_sw_add_en <= 1'b0;
      o_sw_cmd    <= 3'b000;
      o_sw_sel    <= '0;
      o_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            num_q <= num_eff;
            idx   <= '0;
            o_err <= 1'b0;
            state <= (num_eff == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (!cmd_legal) o_err <= 1'b1;
          if (cmd_legal && (entry_beats != '0)) begin
            o_sw_add_en <= entry_add_en;
            o_sw_cmd    <= entry_cmd;
            o_sw_sel    <= entry_sel;
            beat_cnt    <= entry_beats;
            state       <= RUN;
          end else if (last_entry) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end else begin
            idx   <= idx + CFG_AW'(1);
            state <= LOAD;
          end
        end
        RUN: begin
          if (i_data_valid) begin
            beat_cnt <= beat_cnt - CNT_W'(1);
            if (beat_cnt == CNT_W'(1)) state <= HOLD;
          end
        end
        // Control stays put one more cycle so the switch's registered valid sees it.
        HOLD: begin
          if (last_entry) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end else begin
            idx   <= idx + CFG_AW'(1);
            state <= LOAD;
          end
        end
        DRAIN: begin
          if (drain_cnt == DW'(DRAIN_CYC - 1)) state <= DONE;
          else drain_cnt <= drain_cnt + DW'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_switch_cfg_sequencer.sv
`default_nettype none
// Randomized bench: sequences are checked against a table-level model of the
// expected control stream, error flag and completion latency.
module tb_adder_switch_cfg_sequencer;

  localparam int SEL_IN    = 2;
  localparam int NUM_CFG   = 8;
  localparam int CFG_AW    = 3;
  localparam int CNT_W     = 8;
  localparam int DRAIN_CYC = 2;
  localparam int EW        = CNT_W + 4 + SEL_IN;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_wr_en;
  logic [CFG_AW-1:0] cfg_wr_addr;
  logic [EW-1:0]     cfg_wr_data;
  logic [CFG_AW:0]   num_cfg;
  logic              start;
  logic              data_valid;
  logic              data_ready;
  logic              sw_valid;
  logic              sw_add_en;
  logic [2:0]        sw_cmd;
  logic [SEL_IN-1:0] sw_sel;
  logic [CFG_AW-1:0] cfg_idx;
  logic              busy;
  logic              done;
  logic              err;

  int vectors     = 0;
  int miscompares = 0;

  logic [EW-1:0]     model_tbl [NUM_CFG];
  logic [SEL_IN+3:0] model_sw;

  always #5 clk = ~clk;

  adder_switch_cfg_sequencer #(
    .SEL_IN(SEL_IN), .NUM_CFG(NUM_CFG), .CFG_AW(CFG_AW),
    .CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .CLK(clk), .rst_n(rst_n),
    .i_cfg_wr_en(cfg_wr_en), .i_cfg_wr_addr(cfg_wr_addr), .i_cfg_wr_data(cfg_wr_data),
    .i_num_cfg(num_cfg), .i_start(start), .i_data_valid(data_valid),
    .o_data_ready(data_ready), .o_sw_valid(sw_valid), .o_sw_add_en(sw_add_en),
    .o_sw_cmd(sw_cmd), .o_sw_sel(sw_sel), .o_cfg_idx(cfg_idx),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int beats, input int add_en, input int cmd, input int sel);
    logic [CNT_W-1:0]  b = CNT_W'(beats);
    logic              a = 1'(add_en);
    logic [2:0]        c = 3'(cmd);
    logic [SEL_IN-1:0] s = SEL_IN'(sel);
    return {b, a, c, s};
  endfunction

  // Only called while the DUT is idle, so the model always records the write.
  task automatic write_cfg(input int addr, input logic [EW-1:0] data);
    @(negedge clk);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = CFG_AW'(addr);
    cfg_wr_data = data;
    @(negedge clk);
    cfg_wr_en   = 1'b0;
    model_tbl[addr] = data;
  endtask

  // prob < 0 selects a strict 1/0 toggle of i_data_valid.
  task automatic run_seq(input int num, input int prob, input bit disturb,
                         output int done_cyc, output int pulses);
    logic [SEL_IN+3:0] expq[$];
    bit exp_err = 0;
    int active = 0, beats_sum = 0, stalls = 0, total = 0, exp_cyc;
    for (int i = 0; i < num; i++) begin
      int b = int'(model_tbl[i][EW-1:SEL_IN+4]);
      int c = int'(model_tbl[i][SEL_IN+2:SEL_IN]);
      if (c < 2 || c > 5) exp_err = 1;
      else if (b != 0) begin
        active++;
        beats_sum += b;
        for (int k = 0; k < b; k++) expq.push_back(model_tbl[i][SEL_IN+3:0]);
        model_sw = model_tbl[i][SEL_IN+3:0];
      end
    end
    total   = beats_sum;
    exp_cyc = 0;
    @(negedge clk);
    start   = 1'b1;
    num_cfg = (CFG_AW+1)'(num);
    done_cyc = -1;
    pulses   = 0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      start       = disturb && (cyc == 3);
      cfg_wr_en   = disturb && (cyc == 3);
      cfg_wr_addr = '0;
      cfg_wr_data = mk(9, 0, 3, 0);
      data_valid  = (prob < 0) ? ((cyc % 2) == 0) : (int'($urandom_range(99)) < prob);
      #1;
      if (data_ready && !data_valid) stalls++;
      check_value("valid_gate", {31'd0, sw_valid}, {31'd0, data_valid & data_ready});
      if (sw_valid) begin
        pulses++;
        if (expq.size() == 0) check_value("pulse_count_over", pulses, total);
        else check_value("pulse_ctl", {sw_add_en, sw_cmd, sw_sel}, expq.pop_front());
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    start     = 1'b0;
    cfg_wr_en = 1'b0;
    exp_cyc = (num == 0) ? 1 : num + beats_sum + stalls + active + DRAIN_CYC + 1;
    check_value("done_cycle", done_cyc, exp_cyc);
    check_value("pulse_count", pulses, total);
    check_value("err_flag", {31'd0, err}, {31'd0, exp_err});
    check_value("sw_retained", {sw_add_en, sw_cmd, sw_sel}, model_sw);
    check_value("busy_at_done", {31'd0, busy}, 32'd1);
    check_value("ready_at_done", {31'd0, data_ready}, 32'd0);
    if (num > 0) check_value("idx_at_done", cfg_idx, num - 1);
    @(negedge clk);
    #1;
    check_value("done_pulse_end", {31'd0, done}, 32'd0);
    check_value("idle_after_done", {31'd0, busy}, 32'd0);
    check_value("err_sticky", {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, p;
    rst_n = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    num_cfg = '0; start = 1'b0; data_valid = 1'b0;
    model_sw = '0;
    for (int i = 0; i < NUM_CFG; i++) model_tbl[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    check_value("rst_busy", {31'd0, busy}, 32'd0);
    check_value("rst_ready", {31'd0, data_ready}, 32'd0);
    check_value("rst_done", {31'd0, done}, 32'd0);
    check_value("rst_err", {31'd0, err}, 32'd0);
    check_value("rst_sw", {sw_add_en, sw_cmd, sw_sel}, 32'd0);
    check_value("rst_idx", cfg_idx, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single entry, valid always high: done lands 8 cycles after start.
    write_cfg(0, mk(3, 1, 2, 1));
    run_seq(1, 100, 0, d, p);
    check_value("one_entry_latency", d, 8);
    check_value("one_entry_pulses", p, 3);

    // Two entries with toggling valid.
    write_cfg(0, mk(2, 0, 3, 0));
    write_cfg(1, mk(1, 0, 4, 3));
    run_seq(2, -1, 0, d, p);
    check_value("toggle_pulses", p, 3);

    // Illegal cmd and zero-beat entries are skipped.
    write_cfg(0, mk(5, 0, 1, 0));
    write_cfg(1, mk(0, 1, 2, 2));
    write_cfg(2, mk(1, 1, 2, 2));
    run_seq(3, 100, 0, d, p);
    check_value("skip_pulses", p, 1);
    check_value("skip_latency", d, 8);

    // Empty sequence.
    run_seq(0, 100, 0, d, p);
    check_value("num0_latency", d, 1);

    // Start and table write while running must be ignored; rerun proves table intact.
    write_cfg(0, mk(6, 1, 5, 3));
    run_seq(1, 70, 1, d, p);
    run_seq(1, 100, 0, d, p);
    check_value("table_intact_pulses", p, 6);

    // Asynchronous reset in the middle of RUN.
    write_cfg(0, mk(200, 1, 2, 1));
    @(negedge clk);
    start = 1'b1; num_cfg = 4'd1;
    @(negedge clk);
    start = 1'b0; data_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_value("pre_rst_ready", {31'd0, data_ready}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_value("midrst_busy", {31'd0, busy}, 32'd0);
    check_value("midrst_ready", {31'd0, data_ready}, 32'd0);
    check_value("midrst_cmd", {29'd0, sw_cmd}, 32'd0);
    check_value("midrst_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < NUM_CFG; i++) model_tbl[i] = '0;
    model_sw = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(1, 100, 0, d, p);
    check_value("cleared_table_latency", d, 4);

    // Randomized programs.
    for (int it = 0; it < 25; it++) begin
      int nw = int'($urandom_range(NUM_CFG));
      for (int w = 0; w < nw; w++)
        write_cfg(int'($urandom_range(NUM_CFG - 1)),
                  mk(int'($urandom_range(6)), int'($urandom_range(1)),
                     int'($urandom_range(7)), int'($urandom_range(3))));
      run_seq(int'($urandom_range(NUM_CFG)), int'($urandom_range(100, 30)), 0, d, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
